// File: rtl/grid_ram_pkg.sv
// Shared constants and clear-sequencer state encoding for the dual-port grid RAM.
package grid_ram_pkg;

  localparam int RDW_OLD = 0;
  localparam int RDW_NEW = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DONE  = 2'd2
  } clr_state_e;

endpackage

// File: rtl/grid_clear_fsm.sv
// Clear sequencer: walks every cell address once, then pulses done.
module grid_clear_fsm
  import grid_ram_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int DEPTH      = 640,
  parameter int AUTO_CLEAR = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_clear_start,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_wr_sel,
  output logic [ADDR_WIDTH-1:0] o_wr_addr
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  clr_state_e            r_state;
  clr_state_e            w_state_next;
  logic [ADDR_WIDTH-1:0] r_cnt;
  logic [ADDR_WIDTH-1:0] w_cnt_next;
  // Set by reset so the first clocked cycle after release launches a clear.
  logic                  r_auto_pend;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_auto_pend <= (AUTO_CLEAR != 0);
    end else begin
      r_state     <= w_state_next;
      r_cnt       <= w_cnt_next;
      r_auto_pend <= 1'b0;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      IDLE: begin
        if (i_clear_start || r_auto_pend) begin
          w_state_next = CLEAR;
          w_cnt_next   = '0;
        end
      end
      CLEAR: begin
        if (r_cnt == LAST_ADDR) begin
          w_state_next = DONE;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      DONE: begin
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  assign o_busy    = (r_state == CLEAR) || (r_state == DONE);
  assign o_done    = (r_state == DONE);
  assign o_wr_sel  = (r_state == CLEAR);
  assign o_wr_addr = r_cnt;

endmodule

// File: rtl/grid_ram_dp.sv
// Dual-port grid cell store: port A read/write for game logic, port B read-only
// for scan-out, with a built-in clear sequencer that owns the write port while busy.
module grid_ram_dp
  import grid_ram_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 10,
  parameter int                    DATA_WIDTH = 2,
  parameter int                    DEPTH      = 640,
  parameter logic [DATA_WIDTH-1:0] FILL_VALUE = '0,
  parameter int                    AUTO_CLEAR = 1,
  parameter int                    RDW_MODE   = 0
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_a_en,
  input  logic                  i_a_write,
  input  logic [ADDR_WIDTH-1:0] i_a_addr,
  input  logic [DATA_WIDTH-1:0] i_a_data,
  output logic [DATA_WIDTH-1:0] o_a_data,
  output logic                  o_a_valid,
  input  logic                  i_b_en,
  input  logic [ADDR_WIDTH-1:0] i_b_addr,
  output logic [DATA_WIDTH-1:0] o_b_data,
  output logic                  o_b_valid,
  input  logic                  i_clear_start,
  output logic                  o_clear_busy,
  output logic                  o_clear_done
);

  localparam logic [ADDR_WIDTH:0] DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] r_mem [0:DEPTH-1];

  logic                  w_busy;
  logic                  w_clr_sel;
  logic [ADDR_WIDTH-1:0] w_clr_addr;
  logic                  w_a_go;
  logic                  w_a_in_range;
  logic                  w_b_in_range;
  logic                  w_we;
  logic [ADDR_WIDTH-1:0] w_waddr;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic                  w_b_bypass;

  logic [DATA_WIDTH-1:0] r_a_data;
  logic                  r_a_valid;
  logic [DATA_WIDTH-1:0] r_b_data;
  logic                  r_b_valid;

  grid_clear_fsm #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (DEPTH),
    .AUTO_CLEAR (AUTO_CLEAR)
  ) u_clear_fsm (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_clear_start (i_clear_start),
    .o_busy        (w_busy),
    .o_done        (o_clear_done),
    .o_wr_sel      (w_clr_sel),
    .o_wr_addr     (w_clr_addr)
  );

  assign w_a_go       = i_a_en && !w_busy;
  assign w_a_in_range = ({1'b0, i_a_addr} < DEPTH_EXT);
  assign w_b_in_range = ({1'b0, i_b_addr} < DEPTH_EXT);

  // The sequencer owns the single write port while clearing; port A is locked out.
  assign w_we    = w_clr_sel || (w_a_go && i_a_write && w_a_in_range);
  assign w_waddr = w_clr_sel ? w_clr_addr : i_a_addr;
  assign w_wdata = w_clr_sel ? FILL_VALUE : i_a_data;

  assign w_b_bypass = (RDW_MODE == RDW_NEW) && w_we && (w_waddr == i_b_addr);

  always_ff @(posedge i_clk) begin
    if (w_we) begin
      r_mem[w_waddr] <= w_wdata;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_a_data  <= '0;
      r_a_valid <= 1'b0;
      r_b_data  <= '0;
      r_b_valid <= 1'b0;
    end else begin
      r_a_valid <= w_a_go && !i_a_write;
      if (w_a_go && !i_a_write) begin
        r_a_data <= w_a_in_range ? r_mem[i_a_addr] : '0;
      end
      r_b_valid <= i_b_en;
      if (i_b_en) begin
        if (!w_b_in_range) begin
          r_b_data <= '0;
        end else if (w_b_bypass) begin
          r_b_data <= w_wdata;
        end else begin
          r_b_data <= r_mem[i_b_addr];
        end
      end
    end
  end

  assign o_a_data     = r_a_data;
  assign o_a_valid    = r_a_valid;
  assign o_b_data     = r_b_data;
  assign o_b_valid    = r_b_valid;
  assign o_clear_busy = w_busy;

endmodule

// File: tb/tb_grid_ram_dp.sv
// Directed bench for grid_ram_dp: one instance with defaults (auto clear, old-data RDW),
// one with AUTO_CLEAR=0, RDW new-data and FILL_VALUE=2'b01.
module tb_grid_ram_dp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // Instance 0 signals
  logic       rst0_n, a_en0, a_wr0, b_en0, start0;
  logic [9:0] a_addr0, b_addr0;
  logic [1:0] a_din0, a_dout0, b_dout0;
  logic       a_val0, b_val0, busy0, done0;

  // Instance 1 signals
  logic       rst1_n, a_en1, a_wr1, b_en1, start1;
  logic [9:0] a_addr1, b_addr1;
  logic [1:0] a_din1, a_dout1, b_dout1;
  logic       a_val1, b_val1, busy1, done1;

  grid_ram_dp u_dut0 (
    .i_clk(clk), .i_rst_n(rst0_n),
    .i_a_en(a_en0), .i_a_write(a_wr0), .i_a_addr(a_addr0), .i_a_data(a_din0),
    .o_a_data(a_dout0), .o_a_valid(a_val0),
    .i_b_en(b_en0), .i_b_addr(b_addr0), .o_b_data(b_dout0), .o_b_valid(b_val0),
    .i_clear_start(start0), .o_clear_busy(busy0), .o_clear_done(done0)
  );

  grid_ram_dp #(
    .FILL_VALUE (2'b01),
    .AUTO_CLEAR (0),
    .RDW_MODE   (1)
  ) u_dut1 (
    .i_clk(clk), .i_rst_n(rst1_n),
    .i_a_en(a_en1), .i_a_write(a_wr1), .i_a_addr(a_addr1), .i_a_data(a_din1),
    .o_a_data(a_dout1), .o_a_valid(a_val1),
    .i_b_en(b_en1), .i_b_addr(b_addr1), .o_b_data(b_dout1), .o_b_valid(b_val1),
    .i_clear_start(start1), .o_clear_busy(busy1), .o_clear_done(done1)
  );

  typedef struct {
    logic       a_en;
    logic       a_wr;
    logic [9:0] a_addr;
    logic [1:0] a_dat;
    logic       b_en;
    logic [9:0] b_addr;
    logic       ea_v;
    logic [1:0] ea_d;
    logic       eb_v;
    logic [1:0] eb_d;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wr1(input logic [9:0] addr, input logic [1:0] dat);
    a_en1 = 1'b1; a_wr1 = 1'b1; a_addr1 = addr; a_din1 = dat;
    tick();
    a_en1 = 1'b0; a_wr1 = 1'b0;
  endtask

  task automatic rd1(input logic [9:0] addr, output logic [1:0] dat, output logic vld);
    a_en1 = 1'b1; a_wr1 = 1'b0; a_addr1 = addr;
    tick();
    dat = a_dout1; vld = a_val1;
    a_en1 = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  initial begin
    int         busy_cnt, done_cnt, bmiss, abad;
    logic [1:0] d;
    logic       v;

    rst0_n = 1'b0; a_en0 = 1'b0; a_wr0 = 1'b0; a_addr0 = '0; a_din0 = '0;
    b_en0 = 1'b0; b_addr0 = '0; start0 = 1'b0;
    rst1_n = 1'b0; a_en1 = 1'b0; a_wr1 = 1'b0; a_addr1 = '0; a_din1 = '0;
    b_en1 = 1'b0; b_addr1 = '0; start1 = 1'b0;

    //                a_en  a_wr  a_addr   a_dat  b_en  b_addr   ea_v  ea_d   eb_v  eb_d
    vecs[0]  = '{1'b1, 1'b1, 10'd5,   2'b11, 1'b1, 10'd5,   1'b0, 2'b00, 1'b1, 2'b00};
    vecs[1]  = '{1'b1, 1'b0, 10'd5,   2'b00, 1'b1, 10'd5,   1'b1, 2'b11, 1'b1, 2'b11};
    vecs[2]  = '{1'b1, 1'b1, 10'd7,   2'b01, 1'b0, 10'd0,   1'b0, 2'b11, 1'b0, 2'b11};
    vecs[3]  = '{1'b1, 1'b1, 10'd7,   2'b10, 1'b1, 10'd7,   1'b0, 2'b11, 1'b1, 2'b01};
    vecs[4]  = '{1'b1, 1'b0, 10'd7,   2'b00, 1'b1, 10'd7,   1'b1, 2'b10, 1'b1, 2'b10};
    vecs[5]  = '{1'b1, 1'b1, 10'd700, 2'b11, 1'b1, 10'd700, 1'b0, 2'b10, 1'b1, 2'b00};
    vecs[6]  = '{1'b1, 1'b0, 10'd700, 2'b00, 1'b1, 10'd60,  1'b1, 2'b00, 1'b1, 2'b00};
    vecs[7]  = '{1'b1, 1'b0, 10'd188, 2'b00, 1'b1, 10'd639, 1'b1, 2'b00, 1'b1, 2'b00};
    vecs[8]  = '{1'b0, 1'b0, 10'd0,   2'b00, 1'b0, 10'd0,   1'b0, 2'b00, 1'b0, 2'b00};
    vecs[9]  = '{1'b0, 1'b1, 10'd5,   2'b00, 1'b1, 10'd5,   1'b0, 2'b00, 1'b1, 2'b11};
    vecs[10] = '{1'b1, 1'b0, 10'd1023,2'b00, 1'b1, 10'd640, 1'b1, 2'b00, 1'b1, 2'b00};

    repeat (3) tick();
    chk("rst_a_data",  int'(a_dout0), 0);
    chk("rst_a_valid", int'(a_val0),  0);
    chk("rst_b_data",  int'(b_dout0), 0);
    chk("rst_b_valid", int'(b_val0),  0);
    chk("rst_busy",    int'(busy0),   0);
    chk("rst_done",    int'(done0),   0);

    // Auto clear after reset release: expect DEPTH+1 busy cycles and one done pulse.
    rst0_n = 1'b1;
    busy_cnt = 0; done_cnt = 0;
    for (int i = 0; i < 800; i++) begin
      tick();
      busy_cnt += int'(busy0);
      done_cnt += int'(done0);
    end
    $display("auto clear: busy cycles %0d, done pulses %0d", busy_cnt, done_cnt);
    chk("auto_busy_cycles", busy_cnt, 641);
    chk("auto_done_pulses", done_cnt, 1);

    b_en0 = 1'b1; b_addr0 = 10'd639;
    tick();
    b_en0 = 1'b0;
    $display("port B read 639 after auto clear: data %0d valid %0d", b_dout0, b_val0);
    chk("b_read_639_valid", int'(b_val0),  1);
    chk("b_read_639_data",  int'(b_dout0), 0);

    for (int i = 0; i < 11; i++) begin
      a_en0 = vecs[i].a_en; a_wr0 = vecs[i].a_wr; a_addr0 = vecs[i].a_addr; a_din0 = vecs[i].a_dat;
      b_en0 = vecs[i].b_en; b_addr0 = vecs[i].b_addr;
      tick();
      $display("vec %0d: a_en=%0d a_wr=%0d a_addr=%0d b_en=%0d b_addr=%0d -> a %0d/%0d b %0d/%0d",
               i, vecs[i].a_en, vecs[i].a_wr, vecs[i].a_addr, vecs[i].b_en, vecs[i].b_addr,
               a_val0, a_dout0, b_val0, b_dout0);
      chk($sformatf("vec%0d_a_valid", i), int'(a_val0),  int'(vecs[i].ea_v));
      chk($sformatf("vec%0d_a_data",  i), int'(a_dout0), int'(vecs[i].ea_d));
      chk($sformatf("vec%0d_b_valid", i), int'(b_val0),  int'(vecs[i].eb_v));
      chk($sformatf("vec%0d_b_data",  i), int'(b_dout0), int'(vecs[i].eb_d));
    end
    a_en0 = 1'b0; a_wr0 = 1'b0; b_en0 = 1'b0;

    // Instance 1: no auto clear.
    rst1_n = 1'b1;
    tick();
    tick();
    chk("noauto_busy", int'(busy1), 0);

    wr1(10'd3,   2'b11);
    wr1(10'd7,   2'b01);
    wr1(10'd400, 2'b10);
    wr1(10'd299, 2'b11);

    // Same-cycle write/read with new-data bypass.
    a_en1 = 1'b1; a_wr1 = 1'b1; a_addr1 = 10'd7; a_din1 = 2'b10;
    b_en1 = 1'b1; b_addr1 = 10'd7;
    tick();
    a_en1 = 1'b0; a_wr1 = 1'b0; b_en1 = 1'b0;
    $display("rdw new: b data %0d valid %0d", b_dout1, b_val1);
    chk("rdw_new_b_data",  int'(b_dout1), 2);
    chk("rdw_new_b_valid", int'(b_val1),  1);

    // Commanded clear with a locked-out port-A write, a dropped read and a
    // repeated start, while port B keeps reading addr 3.
    start1 = 1'b1; b_en1 = 1'b1; b_addr1 = 10'd3;
    tick();
    start1 = 1'b0;
    busy_cnt = 0; done_cnt = 0; bmiss = 0; abad = 0;
    for (int i = 0; i < 1000; i++) begin
      busy_cnt += int'(busy1);
      done_cnt += int'(done1);
      if (busy1 && !b_val1) bmiss++;
      if (busy1 && a_val1)  abad++;
      a_en1 = 1'b0; a_wr1 = 1'b0; start1 = 1'b0;
      if (i == 100) begin
        a_en1 = 1'b1; a_wr1 = 1'b1; a_addr1 = 10'd3; a_din1 = 2'b10;
      end
      if (i == 101) begin
        a_en1 = 1'b1; a_wr1 = 1'b0; a_addr1 = 10'd3;
      end
      if (i == 200) start1 = 1'b1;
      tick();
    end
    b_en1 = 1'b0;
    $display("cmd clear: busy %0d done %0d b_missing %0d a_valid_while_busy %0d",
             busy_cnt, done_cnt, bmiss, abad);
    chk("cmd_busy_cycles",       busy_cnt, 641);
    chk("cmd_done_pulses",       done_cnt, 1);
    chk("b_valid_during_clear",  bmiss,    0);
    chk("a_valid_during_clear",  abad,     0);
    chk("b_addr3_after_clear",   int'(b_dout1), 1);

    rd1(10'd3, d, v);
    $display("A read 3 after clear: data %0d valid %0d", d, v);
    chk("a_addr3_after_clear_data",  int'(d), 1);
    chk("a_addr3_after_clear_valid", int'(v), 1);
    rd1(10'd400, d, v);
    chk("a_addr400_after_clear", int'(d), 1);

    // Abort a clear by reset once 300 cells have been written.
    wr1(10'd400, 2'b10);
    wr1(10'd299, 2'b11);
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    chk("partial_busy_started", int'(busy1), 1);
    repeat (300) tick();
    rst1_n = 1'b0;
    #1;
    $display("reset mid-clear: busy %0d", busy1);
    chk("async_busy_drop", int'(busy1), 0);
    tick();
    rst1_n = 1'b1;
    tick();
    tick();
    chk("no_restart_busy", int'(busy1), 0);
    rd1(10'd299, d, v);
    $display("A read 299 after abort: data %0d valid %0d", d, v);
    chk("abort_addr299", int'(d), 1);
    rd1(10'd400, d, v);
    $display("A read 400 after abort: data %0d valid %0d", d, v);
    chk("abort_addr400", int'(d), 2);
    b_en1 = 1'b1; b_addr1 = 10'd400;
    tick();
    b_en1 = 1'b0;
    chk("abort_b_addr400", int'(b_dout1), 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
